// File: rtl/ara_inval_line_queue_if.sv
// ---------------------------------------------------------------------------
// ara_inval_line_queue_if
// Purpose : valid/ready handshake bundle carrying one invalidation address.
//           The same bundle is used on both sides of the invalidation queue:
//           the filter side (queue is the slave) and the core side (queue is
//           the master).
// Signals : addr   AddrWidth  byte/line address travelling with the request
//           valid  1          request is valid this cycle
//           ready  1          receiver accepts the request this cycle
// Modports: master drives addr/valid and samples ready,
//           slave samples addr/valid and drives ready.
// ---------------------------------------------------------------------------
interface ara_inval_line_queue_if #(
    parameter int unsigned AddrWidth = 64
);
    logic [AddrWidth-1:0] addr;
    logic                 valid;
    logic                 ready;

    modport master (
        output addr,
        output valid,
        input  ready
    );

    modport slave (
        input  addr,
        input  valid,
        output ready
    );
endinterface

// File: rtl/ara_inval_line_queue.sv
// ---------------------------------------------------------------------------
// ara_inval_line_queue
// Purpose : Buffers the cache-invalidation requests produced by the AXI
//           invalidation filter for Ara's vector stores, aligns them to the
//           L1 D$ line size and hands them to CVA6's D$ invalidation port.
//           Decouples filter stalls from core back-pressure.
// Parameters:
//   AddrWidth    address width (system AXI address width)
//   L1LineWidth  L1 D$ line size in bytes, power of two, >= 2
//   Depth        number of queue entries, power of two, >= 2
// Ports   :
//   clk_i      in   clock
//   rst_ni     in   synchronous active-low reset
//   en_i       in   coherence enable; when low, requests are accepted and dropped
//   inval_req  slave  if  filter side: addr (byte address), valid, ready
//   inval_rsp  master if  core side: addr (line address), valid, ready
//   count_o    out  number of occupied entries
//   empty_o    out  queue is empty
// Configuration macro:
//   ARA_INVAL_COALESCE_EN  when defined, a request whose line already sits in
//                          the queue is accepted and dropped (duplicate
//                          suppression). When undefined, no comparators exist
//                          and every enabled request is enqueued.
// ---------------------------------------------------------------------------
module ara_inval_line_queue #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    ara_inval_line_queue_if.slave        inval_req,
    ara_inval_line_queue_if.master       inval_rsp,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(L1LineWidth - 1));
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wPtr_q, wPtr_d;
    logic [PtrW-1:0]      rPtr_q, rPtr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic [AddrWidth-1:0] reqLine;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic                 push;
    logic                 hit;
    logic                 readyIn;

    // Line alignment of the incoming byte address plus the basic occupancy
    // and handshake terms that everything else is built from.
    always_comb begin
        reqLine = inval_req.addr & LineMask;
        full    = (count_q == DepthCnt);
        pop     = (count_q != '0) && inval_rsp.ready;
        accept  = inval_req.valid && readyIn;
    end

`ifdef ARA_INVAL_COALESCE_EN
    logic            matchHead;
    logic            matchOther;
    logic [PtrW-1:0] offset;

    // Duplicate detection. The head entry is compared separately because a
    // match against a head that is leaving this cycle must not suppress the
    // new request (the store that caused it may be newer than the popped
    // invalidation). Ready is derived from the pop-independent terms so the
    // core's ready never reaches the filter's ready combinationally; a head
    // match on a full queue is still safe to accept because either it is a
    // hit (head stays) or the head is popping and frees its slot.
    always_comb begin
        matchHead  = en_i && (count_q != '0) && (mem_q[rPtr_q] == reqLine);
        matchOther = 1'b0;
        offset     = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            offset = PtrW'(i) - rPtr_q;
            if ((offset != '0) && (CntW'(offset) < count_q) && (mem_q[i] == reqLine)) begin
                matchOther = en_i;
            end
        end
        hit     = matchOther || (matchHead && !pop);
        readyIn = !en_i || !full || matchOther || matchHead;
    end
`else
    // No duplicate suppression: only a full queue with coherence enabled
    // stalls the filter.
    always_comb begin
        hit     = 1'b0;
        readyIn = !en_i || !full;
    end
`endif

    // Next-state computation for the pointers and the occupancy counter.
    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        push    = accept && en_i && !hit;
        wPtr_d  = push ? wPtr_q + 1'b1 : wPtr_q;
        rPtr_d  = pop  ? rPtr_q + 1'b1 : rPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers. Reset clears the storage too so the output address
    // reads zero until the first entry arrives. When a full queue pushes
    // while popping, wPtr equals rPtr and the write lands in the slot that
    // is being vacated.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wPtr_q  <= '0;
            rPtr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wPtr_q  <= wPtr_d;
            rPtr_q  <= rPtr_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wPtr_q] <= reqLine;
            end
        end
    end

    // Outputs come straight from state, so nothing is bypassed within a cycle.
    always_comb begin
        inval_req.ready = readyIn;
        inval_rsp.valid = (count_q != '0);
        inval_rsp.addr  = mem_q[rPtr_q];
        count_o         = count_q;
        empty_o         = (count_q == '0);
    end

endmodule

// File: tb/tb_ara_inval_line_queue.sv
// ---------------------------------------------------------------------------
// tb_ara_inval_line_queue
// Directed bench for ara_inval_line_queue with AddrWidth=64, L1LineWidth=16,
// Depth=4. Inputs change #1 after the rising edge; outputs are compared after
// the inputs have settled, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ara_inval_line_queue;

    localparam int unsigned AddrWidth   = 64;
    localparam int unsigned L1LineWidth = 16;
    localparam int unsigned Depth       = 4;

    logic       clk;
    logic       rstN;
    logic       en;
    logic [2:0] count;
    logic       empty;

    int compareCount = 0;
    int failCount    = 0;

    ara_inval_line_queue_if #(.AddrWidth(AddrWidth)) reqIf ();
    ara_inval_line_queue_if #(.AddrWidth(AddrWidth)) rspIf ();

    ara_inval_line_queue #(
        .AddrWidth   (AddrWidth),
        .L1LineWidth (L1LineWidth),
        .Depth       (Depth)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .en_i      (en),
        .inval_req (reqIf),
        .inval_rsp (rspIf),
        .count_o   (count),
        .empty_o   (empty)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all DUT inputs at once and let them settle.
    task automatic applyStimulus(input logic enIn, input logic validIn,
                                 input logic [63:0] addrIn, input logic readyIn);
        en          = enIn;
        reqIf.valid = validIn;
        reqIf.addr  = addrIn;
        rspIf.ready = readyIn;
        #1;
    endtask

    // Advance one rising edge and step clear of it.
    task automatic clockStep();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and reports it when it does not hold.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);

        // Reset held for two edges.
        clockStep();
        clockStep();
        rstN = 1'b1;
        #1;
        checkOutput("rst_valid", 64'(rspIf.valid), 64'h0);
        checkOutput("rst_count", 64'(count), 64'h0);
        checkOutput("rst_empty", 64'(empty), 64'h1);
        checkOutput("rst_ready", 64'(reqIf.ready), 64'h1);
        checkOutput("rst_addr", rspIf.addr, 64'h0);

        // Alignment and one-cycle latency.
        $display("[TB] alignment / latency");
        applyStimulus(1'b1, 1'b1, 64'h8000_1237, 1'b0);
        checkOutput("align_ready", 64'(reqIf.ready), 64'h1);
        checkOutput("align_valid_pre", 64'(rspIf.valid), 64'h0);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("align_valid", 64'(rspIf.valid), 64'h1);
        checkOutput("align_addr", rspIf.addr, 64'h8000_1230);
        checkOutput("align_count", 64'(count), 64'h1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        clockStep();
        checkOutput("align_pop_empty", 64'(empty), 64'h1);
        checkOutput("align_pop_valid", 64'(rspIf.valid), 64'h0);

        // Fill the queue under back-pressure, pointers start at 1 here.
        $display("[TB] full / back-pressure");
        applyStimulus(1'b1, 1'b1, 64'h100, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h200, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h300, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h400, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h500, 1'b0);
        checkOutput("full_count", 64'(count), 64'h4);
        checkOutput("full_ready", 64'(reqIf.ready), 64'h0);
        applyStimulus(1'b1, 1'b1, 64'h500, 1'b1);
        checkOutput("full_ready_popping", 64'(reqIf.ready), 64'h0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h500, 1'b0);
        checkOutput("full_after_pop_count", 64'(count), 64'h3);
        checkOutput("full_after_pop_addr", rspIf.addr, 64'h200);
        checkOutput("full_after_pop_ready", 64'(reqIf.ready), 64'h1);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("full_refill_count", 64'(count), 64'h4);
        checkOutput("drain_0", rspIf.addr, 64'h200);
        clockStep();
        checkOutput("drain_1", rspIf.addr, 64'h300);
        clockStep();
        checkOutput("drain_2", rspIf.addr, 64'h400);
        clockStep();
        checkOutput("drain_3", rspIf.addr, 64'h500);
        checkOutput("drain_3_valid", 64'(rspIf.valid), 64'h1);
        clockStep();
        checkOutput("drain_empty", 64'(empty), 64'h1);

`ifdef ARA_INVAL_COALESCE_EN
        // Duplicate lines are dropped, even into a full queue.
        $display("[TB] coalesce enabled");
        applyStimulus(1'b1, 1'b1, 64'h100, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h108, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h200, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("coal_count", 64'(count), 64'h2);
        applyStimulus(1'b1, 1'b1, 64'h300, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h400, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h200, 1'b0);
        checkOutput("coal_full_count", 64'(count), 64'h4);
        checkOutput("coal_full_hit_ready", 64'(reqIf.ready), 64'h1);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h104, 1'b1);
        checkOutput("coal_hit_dropped", 64'(count), 64'h4);
        checkOutput("race_ready", 64'(reqIf.ready), 64'h1);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("race_count", 64'(count), 64'h4);
        checkOutput("race_out_0", rspIf.addr, 64'h200);
        clockStep();
        checkOutput("race_out_1", rspIf.addr, 64'h300);
        clockStep();
        checkOutput("race_out_2", rspIf.addr, 64'h400);
        clockStep();
        checkOutput("race_out_3", rspIf.addr, 64'h100);
        clockStep();
        checkOutput("race_empty", 64'(empty), 64'h1);
`else
        // Without coalescing every enabled request lands in the queue.
        $display("[TB] coalesce disabled");
        applyStimulus(1'b1, 1'b1, 64'h100, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h108, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h200, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        checkOutput("nocoal_count", 64'(count), 64'h3);
        checkOutput("nocoal_out_0", rspIf.addr, 64'h100);
        clockStep();
        checkOutput("nocoal_out_1", rspIf.addr, 64'h100);
        clockStep();
        checkOutput("nocoal_out_2", rspIf.addr, 64'h200);
        clockStep();
        checkOutput("nocoal_empty", 64'(empty), 64'h1);
`endif

        // Coherence disabled: requests accepted and dropped, queue drains.
        $display("[TB] enable low");
        applyStimulus(1'b1, 1'b1, 64'h600, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h610, 1'b0);
        clockStep();
        applyStimulus(1'b0, 1'b1, 64'h700, 1'b1);
        checkOutput("dis_count", 64'(count), 64'h2);
        checkOutput("dis_ready", 64'(reqIf.ready), 64'h1);
        clockStep();
        checkOutput("dis_drain_count", 64'(count), 64'h1);
        checkOutput("dis_drain_addr", rspIf.addr, 64'h610);
        clockStep();
        checkOutput("dis_final_count", 64'(count), 64'h0);
        checkOutput("dis_final_valid", 64'(rspIf.valid), 64'h0);

        // Reset in the middle of draining discards everything.
        $display("[TB] reset mid-drain");
        applyStimulus(1'b1, 1'b1, 64'h800, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b1, 64'h900, 1'b0);
        clockStep();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        clockStep();
        checkOutput("mid_count", 64'(count), 64'h1);
        checkOutput("mid_addr", rspIf.addr, 64'h900);
        rstN = 1'b0;
        clockStep();
        checkOutput("mid_rst_count", 64'(count), 64'h0);
        checkOutput("mid_rst_empty", 64'(empty), 64'h1);
        checkOutput("mid_rst_valid", 64'(rspIf.valid), 64'h0);
        checkOutput("mid_rst_addr", rspIf.addr, 64'h0);
        rstN = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 64'(reqIf.ready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
